// File: rtl/stacking_feed_sequencer_pkg.sv
// Shared types and widths for the stacking classifier feed sequencer.
package stacking_feed_sequencer_pkg;
  localparam int WEIGHT_W  = 9;
  localparam int FEAT_W    = 2;
  localparam int PRED_W    = 2;
  localparam int DEPTH_DEF = 32;

  localparam logic [1:0] BANK1 = 2'd0;
  localparam logic [1:0] BANK2 = 2'd1;
  localparam logic [1:0] BANK3 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOADED, S_RUN, S_DRAIN, S_WAIT_RES
  } state_e;
endpackage

// File: rtl/stacking_feed_delay.sv
// LAT-deep shift register that keeps {en, features} aligned with memory read latency.
module stacking_feed_delay #(
  parameter int LAT = 1,
  parameter int W   = 7
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  generate
    if (LAT == 0) begin : g_pass
      assign dout = din;
    end else begin : g_dl
      logic [LAT-1:0][W-1:0] pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign dout = pipe[LAT-1];
    end
  endgenerate
endmodule

// File: rtl/stacking_feed_sequencer.sv
// Loads three weight memories from one stream, then feeds per-sample features and collects the result.
// Optional watchdog in WAIT_RES: define STACK_FEED_WDOG_EN (adds wdog_err port and WDOG_CYCLES).
module stacking_feed_sequencer
  import stacking_feed_sequencer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int READ_LAT = 1
`ifdef STACK_FEED_WDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [WEIGHT_W-1:0]       w_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [3*FEAT_W-1:0]       s_data,
  output logic                      write1,
  output logic                      write2,
  output logic                      write3,
  output logic                      read1,
  output logic                      read2,
  output logic                      read3,
  output logic [$clog2(DEPTH)-1:0]  address1,
  output logic [$clog2(DEPTH)-1:0]  address2,
  output logic [$clog2(DEPTH)-1:0]  address3,
  output logic [WEIGHT_W-1:0]       weight1,
  output logic [WEIGHT_W-1:0]       weight2,
  output logic [WEIGHT_W-1:0]       weight3,
  output logic [FEAT_W-1:0]         data1,
  output logic [FEAT_W-1:0]         data2,
  output logic [FEAT_W-1:0]         data3,
  output logic                      en,
  input  logic                      total_ready,
  input  logic [PRED_W-1:0]         total_predict,
  output logic                      res_valid,
  output logic [PRED_W-1:0]         res_pred,
  output logic                      loaded,
  output logic                      busy
`ifdef STACK_FEED_WDOG_EN
  , output logic                    wdog_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e              state;
  logic [1:0]          bank;
  logic [AW-1:0]       addr, idx;
  logic [DW-1:0]       drain_cnt;
  logic [3*FEAT_W-1:0] feat_q;
  logic                strb_q;
  logic                feed;
`ifdef STACK_FEED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
`endif

  assign w_ready = (state == S_LOAD);
  assign s_ready = (state == S_LOADED) || (state == S_RUN);
  assign busy    = (state != S_IDLE) && (state != S_LOADED);
  // a start in LOADED wins over a feature beat
  assign feed    = s_valid && (((state == S_LOADED) && !start) || (state == S_RUN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      bank <= '0; addr <= '0; idx <= '0; drain_cnt <= '0;
      write1 <= 1'b0; write2 <= 1'b0; write3 <= 1'b0;
      read1 <= 1'b0; read2 <= 1'b0; read3 <= 1'b0;
      address1 <= '0; address2 <= '0; address3 <= '0;
      weight1 <= '0; weight2 <= '0; weight3 <= '0;
      feat_q <= '0; strb_q <= 1'b0;
      res_valid <= 1'b0; res_pred <= '0; loaded <= 1'b0;
`ifdef STACK_FEED_WDOG_EN
      wd_cnt <= '0; wdog_err <= 1'b0;
`endif
    end else begin
      write1 <= 1'b0; write2 <= 1'b0; write3 <= 1'b0;
      read1 <= 1'b0; read2 <= 1'b0; read3 <= 1'b0;
      res_valid <= 1'b0;
      strb_q <= 1'b0;
`ifdef STACK_FEED_WDOG_EN
      if (state != S_WAIT_RES) wd_cnt <= '0;
      if (start && (state == S_IDLE || state == S_LOADED)) wdog_err <= 1'b0;
`endif
      if (feed) begin
        read1 <= 1'b1; read2 <= 1'b1; read3 <= 1'b1;
        address1 <= idx; address2 <= idx; address3 <= idx;
        feat_q <= s_data;
        strb_q <= 1'b1;
        idx <= (idx == LAST) ? '0 : idx + AW'(1);
      end
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD; bank <= BANK1; addr <= '0;
        end
        S_LOAD: if (w_valid) begin
          if (bank == BANK1)      begin write1 <= 1'b1; address1 <= addr; weight1 <= w_data; end
          else if (bank == BANK2) begin write2 <= 1'b1; address2 <= addr; weight2 <= w_data; end
          else                    begin write3 <= 1'b1; address3 <= addr; weight3 <= w_data; end
          if (addr == LAST) begin
            addr <= '0;
            if (bank == BANK3) begin
              bank <= BANK1; loaded <= 1'b1; state <= S_LOADED;
            end else begin
              bank <= bank + 2'd1;
            end
          end else begin
            addr <= addr + AW'(1);
          end
        end
        S_LOADED: if (start) begin
          state <= S_LOAD; loaded <= 1'b0; bank <= BANK1; addr <= '0;
        end else if (s_valid) begin
          state <= (idx == LAST) ? S_DRAIN : S_RUN;
        end
        S_RUN: if (s_valid && idx == LAST) state <= S_DRAIN;
        S_DRAIN: if (READ_LAT == 0 || drain_cnt == DW'(READ_LAT - 1)) begin
          drain_cnt <= '0; state <= S_WAIT_RES;
        end else begin
          drain_cnt <= drain_cnt + DW'(1);
        end
        S_WAIT_RES: if (total_ready) begin
          res_pred <= total_predict; res_valid <= 1'b1; state <= S_LOADED;
        end
`ifdef STACK_FEED_WDOG_EN
        else if (wd_cnt == WW'(WDOG_CYCLES - 1)) begin
          wdog_err <= 1'b1; res_valid <= 1'b1; res_pred <= '0; state <= S_LOADED;
        end else begin
          wd_cnt <= wd_cnt + WW'(1);
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  stacking_feed_delay #(.LAT(READ_LAT), .W(1 + 3*FEAT_W)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({strb_q, feat_q}),
    .dout ({en, data3, data2, data1})
  );
endmodule

// File: tb/tb_stacking_feed_sequencer.sv
// Randomized self-checking bench: load/feed/result flow checked against a queue-based model.
module tb_stacking_feed_sequencer;
  localparam int DEPTH = 32, LAT = 1, NW = 3*DEPTH;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic w_valid = 1'b0, s_valid = 1'b0, total_ready = 1'b0;
  logic [8:0] w_data = '0;
  logic [5:0] s_data = '0;
  logic [1:0] total_predict = '0;
  logic w_ready, s_ready, write1, write2, write3, read1, read2, read3, en;
  logic [4:0] address1, address2, address3;
  logic [8:0] weight1, weight2, weight3;
  logic [1:0] data1, data2, data3, res_pred;
  logic res_valid, loaded, busy;
`ifdef STACK_FEED_WDOG_EN
  logic wdog_err;
`endif

  stacking_feed_sequencer #(.DEPTH(DEPTH), .READ_LAT(LAT)
`ifdef STACK_FEED_WDOG_EN
    , .WDOG_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write1(write1), .write2(write2), .write3(write3),
    .read1(read1), .read2(read2), .read3(read3),
    .address1(address1), .address2(address2), .address3(address3),
    .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .data1(data1), .data2(data2), .data3(data3), .en(en),
    .total_ready(total_ready), .total_predict(total_predict),
    .res_valid(res_valid), .res_pred(res_pred), .loaded(loaded), .busy(busy)
`ifdef STACK_FEED_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // observed strobes, sampled 1 time unit after each rising edge
  int wq[$], rq[$], rcyc[$], eq[$], ecyc[$];
  int cyc = 0, bad_multi = 0, bad_rw = 0, bad_rd = 0, res_cnt = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (int'(write1) + int'(write2) + int'(write3) > 1) bad_multi++;
    if ((write1 | write2 | write3) && (read1 | read2 | read3)) bad_rw++;
    if (write1) wq.push_back(0*100000 + int'(address1)*1000 + int'($signed(weight1)) + 256);
    if (write2) wq.push_back(1*100000 + int'(address2)*1000 + int'($signed(weight2)) + 256);
    if (write3) wq.push_back(2*100000 + int'(address3)*1000 + int'($signed(weight3)) + 256);
    if (read1 | read2 | read3) begin
      if (!(read1 && read2 && read3) || address1 != address2 || address1 != address3) bad_rd++;
      rq.push_back(int'(address1)); rcyc.push_back(cyc);
    end
    if (en) begin eq.push_back(int'({data3, data2, data1})); ecyc.push_back(cyc); end
    if (res_valid) res_cnt++;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // mode 0: back-to-back k-48, 1: w_valid toggling, 2: random gaps and weights
  task automatic do_load(input int mode);
    int acc[$];
    int k = 0, t = 0, wd;
    bit v, wr_ok = 1'b1;
    wq.delete();
    while (k < NW && t < 2000) begin
      @(negedge clk); t++;
      v  = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(t % 2) : ($urandom_range(0, 3) != 0);
      wd = (mode == 2) ? int'($urandom_range(0, 511)) - 256 : k - 48;
      w_valid = v; w_data = wd[8:0];
      if (!w_ready) wr_ok = 1'b0;
      if (v && w_ready) begin acc.push_back(wd); k++; end
    end
    chk("load_beats", k, NW);
    chk("loaded_before_last", loaded, 0);
    @(posedge clk); #1;
    chk("loaded_after_last", loaded, 1);
    @(negedge clk) w_valid = 1'b0;
    chk("w_ready_held", wr_ok, 1);
    chk("w_ready_after_load", w_ready, 0);
    chk("wr_count", wq.size(), NW);
    for (int i = 0; i < NW && i < wq.size(); i++)
      chk($sformatf("wr_ev%0d", i), wq[i], (i / DEPTH)*100000 + (i % DEPTH)*1000 + acc[i] + 256);
    if (mode == 0 && wq.size() == NW) begin
      chk("b1_a0_w", wq[0] % 1000 - 256, -48);
      chk("b3_a31_w", wq[NW-1] % 1000 - 256, 47);
    end
  endtask

  // mode 0: fixed {0,-1,1} back-to-back, 1: random features with gaps
  task automatic do_run(input int mode);
    int fq[$];
    int k = 0, t = 0, r0;
    bit v;
    logic [5:0] fd;
    rq.delete(); rcyc.delete(); eq.delete(); ecyc.delete();
    r0 = res_cnt;
    while (k < DEPTH && t < 2000) begin
      @(negedge clk); t++;
      v  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      fd = (mode == 0) ? 6'b00_11_01 : 6'($urandom);
      s_valid = v; s_data = fd;
      total_ready = (mode == 1) ? 1'($urandom) : 1'b0;
      if (v && s_ready) begin fq.push_back(int'(fd)); k++; end
    end
    @(negedge clk) total_ready = 1'b0;
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    chk("run_beats", k, DEPTH);
    chk("res_ignored_early", res_cnt, r0);
    chk("rd_count", rq.size(), DEPTH);
    chk("en_count", eq.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < rq.size() && i < eq.size(); i++) begin
      chk($sformatf("rd_addr%0d", i), rq[i], i);
      chk($sformatf("en_data%0d", i), eq[i], fq[i]);
      chk($sformatf("en_lag%0d", i), ecyc[i] - rcyc[i], LAT);
    end
    chk("busy_wait_res", busy, 1);
    chk("s_ready_wait_res", s_ready, 0);
  endtask

  task automatic finish_res(input int p);
    int r0 = res_cnt;
    @(negedge clk) begin total_ready = 1'b1; total_predict = p[1:0]; end
    @(posedge clk); #1;
    chk("res_valid_pulse", res_valid, 1);
    chk("res_pred", res_pred, p & 3);
    @(negedge clk) total_ready = 1'b0;
    @(posedge clk); #1;
    chk("res_valid_single", res_valid, 0);
    chk("res_pulses", res_cnt - r0, 1);
    chk("loaded_state", {busy, s_ready, loaded}, 3'b011);
  endtask

  initial begin
    int k, t;
    #12;
    chk("rst_strobes", {write1, write2, write3, read1, read2, read3, en, res_valid}, 0);
    chk("rst_status", {loaded, busy, w_ready, s_ready}, 0);
    chk("rst_buses", {address1, address2, address3, weight1, weight2, weight3}, 0);
    chk("rst_data", {data1, data2, data3, res_pred}, 0);
    @(negedge clk) rst = 1'b1;
    pulse_start();
    chk("load_entered", {busy, w_ready}, 2'b11);

    do_load(0);
    do_run(0);
    finish_res(1);

    // start ignored in WAIT_RES
    do_run(1);
    pulse_start();
    chk("start_ign_wait", {busy, loaded, w_ready}, 3'b110);
    finish_res(2);

    // start in LOADED reloads
    pulse_start();
    chk("reload_clears", {loaded, w_ready}, 2'b01);
    do_load(1);
    do_run(1);
    finish_res(int'($urandom_range(0, 3)));

    // async reset in the middle of RUN at idx=10
    k = 0; t = 0;
    while (k < 10 && t < 500) begin
      @(negedge clk); t++;
      s_valid = 1'b1; s_data = 6'($urandom);
      if (s_ready) k++;
    end
    @(posedge clk); #2;
    chk("pre_rst_read", read1, 1);
    rst = 1'b0; s_valid = 1'b0;
    #1;
    chk("mid_rst_strobes", {write1, write2, write3, read1, read2, read3, en, res_valid}, 0);
    chk("mid_rst_status", {loaded, busy, w_ready, s_ready}, 0);
    chk("mid_rst_buses", {address1, address2, address3, data1, data2, data3}, 0);
    @(negedge clk) rst = 1'b1;
    pulse_start();
    do_load(2);
    do_run(1);
    finish_res(3);

`ifdef STACK_FEED_WDOG_EN
    do_run(0);
    t = 0;
    while (!res_valid && t < 40) begin @(posedge clk); #1; t++; end
    chk("wd_pulse", res_valid, 1);
    chk("wd_err", wdog_err, 1);
    chk("wd_pred", res_pred, 0);
    @(posedge clk); #1;
    chk("wd_loaded", {busy, s_ready}, 2'b01);
    pulse_start();
    chk("wd_clear", wdog_err, 0);
`endif

    chk("one_write_per_cycle", bad_multi, 0);
    chk("no_write_with_read", bad_rw, 0);
    chk("reads_aligned", bad_rd, 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
